mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high; ports clk_i and rst_i.
REQ-002 clk_i  input  1  rising-edge clock.
REQ-003 rst_i  input  1  asynchronous active-high reset.
REQ-004 req_i  input  2  per-requester access request; bit 0 = calculator controller, bit 1 = host loader.
REQ-005 we_i  input  2  per-requester write enable; 0 = read.
REQ-006 lock_i  input  2  per-requester burst lock.
REQ-007 addr_i  input  2 x ADDR_W  per-requester word address.
REQ-008 wdata_i  input  2 x MEM_WORD_SIZE  per-requester write data.
REQ-009 gnt_o  output  2  one-hot-or-zero grant; command accepted in this cycle.
REQ-010 rvalid_o  output  2  read data valid for requester n.
REQ-011 rdata_o  output  MEM_WORD_SIZE  returned read data, shared by both requesters.
REQ-012 mem_read_o  output  1  memory read strobe.
REQ-013 mem_write_o  output  1  memory write strobe.
REQ-014 mem_addr_o  output  ADDR_W  memory address.
REQ-015 mem_wdata_o  output  MEM_WORD_SIZE  memory write data.
REQ-016 mem_rdata_i  input  MEM_WORD_SIZE  memory read data, valid one cycle after mem_read_o.

Function
REQ-017 Grant SHALL be combinational from req_i, state and rr_ptr; memory command SHALL be driven from the granted requester in the same cycle; zero latency.
REQ-018 No grant: mem_read_o = mem_write_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
REQ-019 Granted n: mem_write_o = we_i[n], mem_read_o = !we_i[n], mem_addr_o = addr_i[n], mem_wdata_o = wdata_i[n] (0 on reads).
REQ-020 FSM states: S_IDLE, S_LOCK0, S_LOCK1.
REQ-021 S_IDLE: one requester active -> grant it; both active -> grant rr_ptr; after any grant to n, rr_ptr <= other index.
REQ-022 S_IDLE, granted n with lock_i[n]=1 -> S_LOCKn, lock_cnt <= 0.
REQ-023 S_LOCKn: only n eligible, granted whenever req_i[n]=1; other requester held off; lock_cnt increments each cycle.
REQ-024 S_LOCKn exit to S_IDLE when lock_i[n]=0 (that cycle still grants n if req_i[n]) or lock_cnt reaches LOCK_MAX-1; on exit rr_ptr <= other index.
REQ-025 Read return: granted read in cycle t SHALL assert rvalid_o[n] in t+1 only, rdata_o = mem_rdata_i; rdata_o = 0 when no rvalid.
REQ-026 Writes produce no response; gnt_o is the only acknowledgement.
REQ-027 Back-to-back reads from alternating requesters SHALL each return in order on consecutive cycles, no bubbles.
REQ-028 Both requesting continuously, no lock: grants alternate every cycle.
REQ-029 lock_i asserted without grant has no effect.
REQ-030 Starvation bound: a non-locked requester waits at most LOCK_MAX+1 cycles.

Reset
REQ-031 rst_i asserted: state S_IDLE, rr_ptr 0, lock_cnt 0, read-tag valid 0; all outputs 0 immediately.
REQ-032 A read granted in the cycle reset asserts SHALL never produce rvalid_o.
REQ-033 First cycle after reset with both requesting: grant requester 0.

Structure
REQ-034 calculator_pkg SHALL gain ARB_N = 2, LOCK_MAX = 16, REQ_CALC = 0, REQ_HOST = 1, and the arb_state_t enum; ADDR_W and MEM_WORD_SIZE come from the same package.
REQ-035 Single module, no sub-module; sequential state in one always_ff with async reset, grant/mux in always_comb.

Verification
REQ-036 Only req_i=01, read addr 5, memory holds 64'hA at 5 -> gnt_o=01 same cycle, next cycle rvalid_o=01, rdata_o=64'hA.
REQ-037 req_i=11 held 4 cycles, no lock, after reset -> gnt_o sequence 01,10,01,10; rvalid_o follows one cycle later.
REQ-038 Host lock_i[1]=1 with req 4 cycles while calc requests -> gnt_o=10 x4, lock drop cycle still 10, then 01.
REQ-039 Host lock held 40 cycles, calc requesting -> host granted 16 cycles, then calc granted, rr_ptr = 1.
REQ-040 Host write addr 3 data 64'h55, then calc read addr 3 -> calc rdata_o=64'h55 one cycle after its grant.
REQ-041 Reset asserted mid-cycle of granted read -> outputs 0 at once, no rvalid_o after release, next grant to requester 0.

Source files
------------

// File: rtl/calculator_pkg.sv
// Shared constants and types for the calculator memory subsystem.
package calculator_pkg;

   localparam int unsigned ADDR_W        = 8;
   localparam int unsigned MEM_WORD_SIZE = 64;

   // Memory arbiter configuration
   localparam int unsigned ARB_N      = 2;
   localparam int unsigned LOCK_MAX   = 16;
   localparam int unsigned LOCK_CNT_W = $clog2(LOCK_MAX);
   localparam int unsigned REQ_CALC   = 0;
   localparam int unsigned REQ_HOST   = 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOCK0 = 2'd1,
      S_LOCK1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus of the two-port memory arbiter.
// master: requesters plus memory model; slave: the arbiter itself.
interface mem_arbiter_if;
   import calculator_pkg::*;

   logic [ARB_N-1:0]                     req_i;
   logic [ARB_N-1:0]                     we_i;
   logic [ARB_N-1:0]                     lock_i;
   logic [ARB_N-1:0][ADDR_W-1:0]         addr_i;
   logic [ARB_N-1:0][MEM_WORD_SIZE-1:0]  wdata_i;
   logic [ARB_N-1:0]                     gnt_o;
   logic [ARB_N-1:0]                     rvalid_o;
   logic [MEM_WORD_SIZE-1:0]             rdata_o;
   logic                                 mem_read_o;
   logic                                 mem_write_o;
   logic [ADDR_W-1:0]                    mem_addr_o;
   logic [MEM_WORD_SIZE-1:0]             mem_wdata_o;
   logic [MEM_WORD_SIZE-1:0]             mem_rdata_i;

   modport master (
      output req_i, we_i, lock_i, addr_i, wdata_i, mem_rdata_i,
      input  gnt_o, rvalid_o, rdata_o, mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
   );

   modport slave (
      input  req_i, we_i, lock_i, addr_i, wdata_i, mem_rdata_i,
      output gnt_o, rvalid_o, rdata_o, mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
   );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: zero-latency round-robin grant with optional burst
// lock, one-cycle read return tagged with the requester index.
module mem_arbiter
   import calculator_pkg::*;
(
   input  logic          clk_i,
   input  logic          rst_i,
   mem_arbiter_if.slave  io_bus
);

   arb_state_t             r_state;
   logic                   r_rr_ptr;
   logic [LOCK_CNT_W-1:0]  r_lock_cnt;
   logic                   r_rd_valid;
   logic                   r_rd_idx;

   logic [ARB_N-1:0]       w_gnt;
   logic                   w_any_gnt;
   logic                   w_gnt_idx;
   logic                   w_lock_idx;
   logic [LOCK_CNT_W-1:0]  w_cnt_inc;
   logic                   w_lock_exit;

   assign w_any_gnt  = |w_gnt;
   assign w_gnt_idx  = w_gnt[REQ_HOST];
   assign w_lock_idx = (r_state == S_LOCK1);
   assign w_cnt_inc  = r_lock_cnt + 1'b1;
   // The IDLE grant that opened the burst counts too, so a burst holds LOCK_MAX grants.
   assign w_lock_exit = !io_bus.lock_i[w_lock_idx] ||
                        (w_cnt_inc == LOCK_CNT_W'(LOCK_MAX - 1));

   // Grant decision; forced to zero while reset is asserted so outputs drop at once.
   always_comb begin
      w_gnt = '0;
      if (!rst_i) begin
         case (r_state)
            S_IDLE: begin
               if (&io_bus.req_i) w_gnt[r_rr_ptr] = 1'b1;
               else               w_gnt = io_bus.req_i;
            end
            S_LOCK0: w_gnt[REQ_CALC] = io_bus.req_i[REQ_CALC];
            S_LOCK1: w_gnt[REQ_HOST] = io_bus.req_i[REQ_HOST];
            default: w_gnt = '0;
         endcase
      end
   end

   // Memory command mux from the granted requester and tagged read return.
   always_comb begin
      io_bus.gnt_o       = w_gnt;
      io_bus.mem_read_o  = 1'b0;
      io_bus.mem_write_o = 1'b0;
      io_bus.mem_addr_o  = '0;
      io_bus.mem_wdata_o = '0;
      if (w_any_gnt) begin
         io_bus.mem_write_o = io_bus.we_i[w_gnt_idx];
         io_bus.mem_read_o  = !io_bus.we_i[w_gnt_idx];
         io_bus.mem_addr_o  = io_bus.addr_i[w_gnt_idx];
         if (io_bus.we_i[w_gnt_idx]) io_bus.mem_wdata_o = io_bus.wdata_i[w_gnt_idx];
      end
      io_bus.rvalid_o = '0;
      if (r_rd_valid) io_bus.rvalid_o[r_rd_idx] = 1'b1;
      io_bus.rdata_o = r_rd_valid ? io_bus.mem_rdata_i : '0;
   end

   // Arbitration state, round-robin pointer, burst counter and read tag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_rr_ptr   <= 1'b0;
         r_lock_cnt <= '0;
         r_rd_valid <= 1'b0;
         r_rd_idx   <= 1'b0;
      end else begin
         r_rd_valid <= w_any_gnt && !io_bus.we_i[w_gnt_idx];
         r_rd_idx   <= w_gnt_idx;
         case (r_state)
            S_IDLE: begin
               if (w_any_gnt) begin
                  r_rr_ptr <= ~w_gnt_idx;
                  if (io_bus.lock_i[w_gnt_idx]) begin
                     r_state    <= w_gnt_idx ? S_LOCK1 : S_LOCK0;
                     r_lock_cnt <= '0;
                  end
               end
            end
            S_LOCK0, S_LOCK1: begin
               r_lock_cnt <= w_cnt_inc;
               if (w_lock_exit) begin
                  r_state  <= S_IDLE;
                  r_rr_ptr <= ~w_lock_idx;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a per-cycle reference model and a memory model.
module tb_mem_arbiter;
   import calculator_pkg::*;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;

   mem_arbiter_if u_if ();

   mem_arbiter u_dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .io_bus (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [1:0] req, input logic [1:0] we, input logic [1:0] lock,
                        input logic [7:0] a0, input logic [7:0] a1,
                        input logic [63:0] d0, input logic [63:0] d1);
      u_if.req_i   = req;
      u_if.we_i    = we;
      u_if.lock_i  = lock;
      u_if.addr_i  = {a1, a0};
      u_if.wdata_i = {d1, d0};
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   // Memory behind the arbiter: one-cycle read latency.
   logic [63:0] env_mem [256];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) env_mem[i] <= '0;
         env_mem[5] <= 64'hA;
      end else begin
         if (u_if.mem_write_o) env_mem[u_if.mem_addr_o] <= u_if.mem_wdata_o;
         if (u_if.mem_read_o)  u_if.mem_rdata_i <= env_mem[u_if.mem_addr_o];
      end
   end

   // Reference model: lock owner (-1 none), grants so far in the burst, round-robin choice.
   int          m_owner;
   int          m_burst;
   int          m_rr;
   bit          m_pend;
   int          m_pidx;
   logic [63:0] m_pdata;
   logic [63:0] m_mem [256];
   int          m_g;
   logic [1:0]  e_gnt;
   logic [1:0]  e_rvalid;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_gnt", u_if.gnt_o, 2'b00);
         chk("rst_rvalid", u_if.rvalid_o, 2'b00);
         chk("rst_rdata", u_if.rdata_o, 64'h0);
         chk("rst_mem_rd", u_if.mem_read_o, 1'b0);
         chk("rst_mem_wr", u_if.mem_write_o, 1'b0);
         m_owner = -1;
         m_burst = 0;
         m_rr    = 0;
         m_pend  = 1'b0;
         for (int i = 0; i < 256; i++) m_mem[i] = '0;
         m_mem[5] = 64'hA;
      end else begin
         m_g = -1;
         if (m_owner < 0) begin
            if (u_if.req_i == 2'b11) m_g = m_rr;
            else if (u_if.req_i[0])  m_g = 0;
            else if (u_if.req_i[1])  m_g = 1;
         end else if (u_if.req_i[m_owner]) begin
            m_g = m_owner;
         end
         e_gnt = 2'b00;
         if (m_g >= 0) e_gnt[m_g] = 1'b1;
         e_rvalid = 2'b00;
         if (m_pend) e_rvalid[m_pidx] = 1'b1;
         chk("gnt", u_if.gnt_o, e_gnt);
         chk("rvalid", u_if.rvalid_o, e_rvalid);
         chk("rdata", u_if.rdata_o, m_pend ? m_pdata : 64'h0);
         if (m_g < 0) begin
            chk("idle_rd", u_if.mem_read_o, 1'b0);
            chk("idle_wr", u_if.mem_write_o, 1'b0);
            chk("idle_addr", u_if.mem_addr_o, 8'h0);
            chk("idle_wdata", u_if.mem_wdata_o, 64'h0);
         end else begin
            chk("mem_rd", u_if.mem_read_o, !u_if.we_i[m_g]);
            chk("mem_wr", u_if.mem_write_o, u_if.we_i[m_g]);
            chk("mem_addr", u_if.mem_addr_o, u_if.addr_i[m_g]);
            chk("mem_wdata", u_if.mem_wdata_o, u_if.we_i[m_g] ? u_if.wdata_i[m_g] : 64'h0);
         end
         // Advance the model to the next cycle.
         m_pend = 1'b0;
         if (m_g >= 0) begin
            if (u_if.we_i[m_g]) begin
               m_mem[u_if.addr_i[m_g]] = u_if.wdata_i[m_g];
            end else begin
               m_pend  = 1'b1;
               m_pidx  = m_g;
               m_pdata = m_mem[u_if.addr_i[m_g]];
            end
         end
         if (m_owner < 0) begin
            if (m_g >= 0) begin
               m_rr = 1 - m_g;
               if (u_if.lock_i[m_g]) begin
                  m_owner = m_g;
                  m_burst = 1;
               end
            end
         end else begin
            m_burst++;
            if (!u_if.lock_i[m_owner] || m_burst == int'(LOCK_MAX)) begin
               m_rr    = 1 - m_owner;
               m_owner = -1;
            end
         end
      end
   end

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst    = 1'b1;
      drive(2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 64'h0, 64'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {u_if.gnt_o, u_if.rvalid_o, u_if.mem_read_o}, 5'b0);

      // Both requesting after reset: 01,10,01,10 with reads returning a cycle later.
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(2'b11, 2'b00, 2'b00, 8'(i), 8'(i + 8), 64'h0, 64'h0);
         #1;
         chk("alt_gnt", u_if.gnt_o, (i % 2 == 1) ? 2'b10 : 2'b01);
         if (i > 0) chk("alt_rvalid", u_if.rvalid_o, (i % 2 == 1) ? 2'b01 : 2'b10);
         next();
      end
      drive(2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 64'h0, 64'h0);
      #1;
      chk("alt_last_rvalid", u_if.rvalid_o, 2'b10);
      chk("alt_no_gnt", u_if.gnt_o, 2'b00);
      next();

      // Single calc read of address 5.
      drive(2'b01, 2'b00, 2'b00, 8'd5, 8'd0, 64'h0, 64'h0);
      #1;
      chk("rd5_gnt", u_if.gnt_o, 2'b01);
      chk("rd5_addr", u_if.mem_addr_o, 8'd5);
      next();
      drive(2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 64'h0, 64'h0);
      #1;
      chk("rd5_rvalid", u_if.rvalid_o, 2'b01);
      chk("rd5_rdata", u_if.rdata_o, 64'hA);
      next();

      // Host burst of 4 locked writes while calc keeps requesting.
      for (int i = 0; i < 4; i++) begin
         drive(2'b11, 2'b10, 2'b10, 8'd7, 8'(20 + i), 64'h0, 64'(i + 1));
         #1;
         chk("lock4_gnt", u_if.gnt_o, 2'b10);
         next();
      end
      drive(2'b11, 2'b10, 2'b00, 8'd7, 8'd24, 64'h0, 64'h99);
      #1;
      chk("lock_drop_gnt", u_if.gnt_o, 2'b10);
      next();
      drive(2'b11, 2'b00, 2'b00, 8'd7, 8'd20, 64'h0, 64'h0);
      #1;
      chk("after_lock_gnt", u_if.gnt_o, 2'b01);
      next();
      drive(2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 64'h0, 64'h0);
      next();

      // Host holds lock for 40 cycles: burst capped at LOCK_MAX grants.
      for (int i = 0; i < 40; i++) begin
         drive(2'b11, 2'b11, 2'b10, 8'd100, 8'd101, 64'(i), 64'(i + 64'h100));
         #1;
         if (i < 16)       chk("cap_host", u_if.gnt_o, 2'b10);
         else if (i == 16) chk("cap_calc", u_if.gnt_o, 2'b01);
         else if (i == 17) chk("cap_rr_host", u_if.gnt_o, 2'b10);
         next();
      end
      drive(2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 64'h0, 64'h0);
      next();
      next();

      // Host writes 0x55 to 3, calc reads it back.
      drive(2'b10, 2'b10, 2'b00, 8'd0, 8'd3, 64'h0, 64'h55);
      #1;
      chk("wr3_gnt", u_if.gnt_o, 2'b10);
      chk("wr3_wdata", u_if.mem_wdata_o, 64'h55);
      next();
      drive(2'b01, 2'b00, 2'b00, 8'd3, 8'd0, 64'h0, 64'h0);
      #1;
      chk("rd3_gnt", u_if.gnt_o, 2'b01);
      next();
      drive(2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 64'h0, 64'h0);
      #1;
      chk("rd3_rvalid", u_if.rvalid_o, 2'b01);
      chk("rd3_rdata", u_if.rdata_o, 64'h55);
      next();

      // Host lock without a grant is ignored.
      drive(2'b01, 2'b00, 2'b10, 8'd5, 8'd3, 64'h0, 64'h0);
      #1;
      chk("nolock_gnt0", u_if.gnt_o, 2'b01);
      next();
      drive(2'b11, 2'b00, 2'b00, 8'd5, 8'd3, 64'h0, 64'h0);
      #1;
      chk("nolock_gnt1", u_if.gnt_o, 2'b10);
      next();
      drive(2'b11, 2'b00, 2'b00, 8'd5, 8'd3, 64'h0, 64'h0);
      #1;
      chk("nolock_gnt2", u_if.gnt_o, 2'b01);
      next();

      // Reset arrives mid-cycle while a read is being granted.
      drive(2'b01, 2'b00, 2'b00, 8'd5, 8'd0, 64'h0, 64'h0);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_mid_gnt", u_if.gnt_o, 2'b00);
      chk("rst_mid_rd", u_if.mem_read_o, 1'b0);
      chk("rst_mid_rvalid", u_if.rvalid_o, 2'b00);
      next();
      rst = 1'b0;
      drive(2'b11, 2'b00, 2'b00, 8'd5, 8'd3, 64'h0, 64'h0);
      #1;
      chk("post_rst_rvalid", u_if.rvalid_o, 2'b00);
      chk("post_rst_gnt", u_if.gnt_o, 2'b01);
      next();
      drive(2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 64'h0, 64'h0);
      #1;
      chk("post_rst_rdata", u_if.rdata_o, 64'hA);
      next();
      next();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
